seg7_scan_driver: RTL

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_digit_lut.sv | 18 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are ordered g..a in bits 6..0 and are active-low.
package seg7_pkg;

    typedef logic [3:0] digit_code_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam digit_code_t MAX_BCD = 4'd9;

    // Entry 15 (F) is leftmost, entry 0 rightmost.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_digit_lut.sv
// Maps one digit code to its active-low segment pattern; codes above 9
// render blank unless hex_mode is set.
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[code];
        if (!hex_mode && (code > MAX_BCD)) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with a one-cycle anti-ghost gap per slot.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] code_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    hex_mode,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done,
    output logic                    code_err
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           nxt_idx;
    logic                    started;
    logic                    gap;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] shadow_code;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    digit_code_t             cur_code;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              lut_seg;
    logic                    load_err;

    assign tick = (cnt == CNT_LAST);

    // The first tick after reset only opens the digit-0 slot; later ticks advance.
    always_comb begin
        nxt_idx = idx;
        if (started) begin
            nxt_idx = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    always_comb begin
        load_err = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code_in[4*i +: 4] > MAX_BCD) begin
                load_err = 1'b1;
            end
        end
        load_err = load_err && !hex_mode;
    end

    seg7_digit_lut u_lut (
        .code     (cur_code),
        .hex_mode (hex_mode),
        .seg      (lut_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_code[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_above;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_blank <= 1'b0;
        end else if (tick) begin
            cur_blank <= lz_mask[nxt_idx];
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    // Digit data is latched on the tick edge so a load landing on tick or gap
    // only affects later slots; the LUT and hex_mode are resolved in the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            started    <= 1'b0;
            gap        <= 1'b0;
            cur_code   <= '0;
            cur_dp     <= 1'b0;
            frame_done <= 1'b0;
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
        end else begin
            cnt        <= tick ? '0 : cnt + CW'(1);
            gap        <= tick;
            frame_done <= tick && started && (idx == IDX_LAST);
            if (tick) begin
                started  <= 1'b1;
                idx      <= nxt_idx;
                cur_code <= shadow_code[4*nxt_idx +: 4];
                cur_dp   <= shadow_dp[nxt_idx];
                an_n     <= '1;
                seg_n    <= SEG_BLANK;
                dp_n     <= 1'b1;
            end else if (gap) begin
                an_n  <= ~(NUM_DIGITS'(1) << idx);
                seg_n <= cur_blank ? SEG_BLANK : lut_seg;
                dp_n  <= ~cur_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_code <= '0;
            shadow_dp   <= '0;
            code_err    <= 1'b0;
        end else if (load) begin
            shadow_code <= code_in;
            shadow_dp   <= dp_in;
            code_err    <= load_err;
        end
    end

endmodule
